// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter: shares the integer register file's single write port among NREQ sources.
// Latency: the grant is combinational in cycle N, and the registered wb_* write appears in cycle N+1.
// Backpressure: none toward the register file; exactly one pending request is accepted whenever any req_valid is high.
// Optional decode bypass of the registered write when RF_WB_BYPASS_EN is defined.
module rf_wb_arbiter #(
  parameter int XLEN = 64,
  // legal range 2..8; requester i owns slice i of every packed request bus
  parameter int NREQ = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [5*NREQ-1:0]      req_rd,
  input  logic [XLEN*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   wb_we,
  output logic [4:0]             wb_rd,
  output logic [XLEN-1:0]        wb_data,
  output logic [2:0]             wb_src
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
  output logic [XLEN-1:0]        fwd1_data,
  output logic [XLEN-1:0]        fwd2_data
`endif
);

  // Request buses are widened to 8 entries so a 3-bit requester index selects them exactly.
  logic [7:0]      valid_pad;
  logic [4:0]      rd_arr   [8];
  logic [XLEN-1:0] data_arr [8];

  // Round-robin pointer: the index of the most recently granted requester.
  logic [2:0]      rr_last_q, rr_last_d;

  // Registered write toward the register file.
  logic            wb_we_q,   wb_we_d;
  logic [4:0]      wb_rd_q,   wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [2:0]      wb_src_q,  wb_src_d;

  // Arbitration result for the current cycle.
  logic            grant_vld;
  logic [2:0]      grant_idx;
  logic [4:0]      grant_rd;
  logic [XLEN-1:0] grant_data;
  logic [3:0]      cand_sum;
  logic [2:0]      cand;

  assign valid_pad = 8'(req_valid);

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_slice
      if (g < NREQ) begin : g_live
        assign rd_arr[g]   = req_rd[5*g +: 5];
        assign data_arr[g] = req_data[XLEN*g +: XLEN];
      end else begin : g_tie
        assign rd_arr[g]   = 5'd0;
        assign data_arr[g] = '0;
      end
    end
  endgenerate

  // Search upward from rr_last+1, wrapping modulo NREQ; the first valid requester wins.
  // Reset suppresses the grant, so a request raised during reset stays pending.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 3'd0;
    cand_sum  = 4'd0;
    cand      = 3'd0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_sum = {1'b0, rr_last_q} + 4'(k);
      if (cand_sum >= 4'(NREQ)) begin
        cand_sum = cand_sum - 4'(NREQ);
      end
      cand = cand_sum[2:0];
      if (!grant_vld && valid_pad[cand] && !reset) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Select the winner's payload and drive the one-hot ready.
  always_comb begin
    grant_rd   = rd_arr[grant_idx];
    grant_data = data_arr[grant_idx];
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant_vld && (grant_idx == 3'(i));
    end
  end

  // Next state: the pointer moves only on a grant.
  // A grant to rd==0 still uses the slot, but it never writes.
  always_comb begin
    rr_last_d = rr_last_q;
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_src_d  = wb_src_q;
    if (grant_vld) begin
      rr_last_d = grant_idx;
      wb_we_d   = (grant_rd != 5'd0);
      wb_rd_d   = grant_rd;
      wb_data_d = grant_data;
      wb_src_d  = grant_idx;
    end
  end

  // State registers. Reset leaves the pointer at NREQ-1, so requester 0 leads after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_q <= 3'(NREQ - 1);
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
      wb_src_q  <= 3'd0;
    end else begin
      rr_last_q <= rr_last_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_src_q  <= wb_src_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
  assign wb_src  = wb_src_q;

`ifdef RF_WB_BYPASS_EN
  // Forward the in-flight write to decode; the register file does not return this value until the next cycle.
  always_comb begin
    fwd1_hit  = wb_we_q && (rs1 == wb_rd_q) && (rs1 != 5'd0);
    fwd2_hit  = wb_we_q && (rs2 == wb_rd_q) && (rs2 != 5'd0);
    fwd1_data = fwd1_hit ? wb_data_q : '0;
    fwd2_data = fwd2_hit ? wb_data_q : '0;
  end
`endif

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback arbiter for the pipelined CPU's integer register file. It shares the file's single write port between NREQ writeback sources: ALU pipeline, load/store unit, and multiply/divide unit. It grants one source per cycle in round-robin order and registers the winning write for one cycle before it reaches the register file. An optional bypass lets decode read the registered write before it commits.

## Interface
Parameters:
- XLEN, 64, data width of register writes
- NREQ, 3, number of writeback requesters; legal range 2..8; requester i owns slice i of every packed bus

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  requester i has a write pending
- req_rd  input  5*NREQ  destination register of requester i, bits [5i+4:5i]
- req_data  input  XLEN*NREQ  write data of requester i, bits [XLEN*i+XLEN-1:XLEN*i]
- req_ready  output  NREQ  one-hot grant; the request is consumed in the cycle `valid & ready` is high
- wb_we  output  1  register-file write enable
- wb_rd  output  5  register-file write address
- wb_data  output  XLEN  register-file write data
- wb_src  output  3  index of the requester that produced the current wb_* contents
- rs1, rs2  input  5  decode read addresses (only with RF_WB_BYPASS_EN)
- fwd1_hit, fwd2_hit  output  1  bypass hit (only with RF_WB_BYPASS_EN)
- fwd1_data, fwd2_data  output  XLEN  bypass data (only with RF_WB_BYPASS_EN)

## Operation
- **Reset.** While reset is high:
  - wb_we=0, wb_rd=0, wb_data=0, wb_src=0, req_ready=0.
  - Round-robin pointer rr_last=NREQ-1, so requester 0 has top priority in the first cycle after reset.
- **Priority.** Search starts at index (rr_last+1) mod NREQ and wraps upward. The first requester with req_valid=1 is granted.
- **Grant.** req_ready is combinational from req_valid and rr_last. At most one bit is set. If req_valid=0 then req_ready=0.
- **Pointer update.** rr_last is set to the granted index only in a cycle with a grant. Idle cycles leave it unchanged.
- **Output register.** On each clock edge:
  - If a grant occurred: wb_rd=granted rd, wb_data=granted data, wb_src=granted index, and wb_we=1 unless rd==0.
  - Otherwise: wb_we=0, with wb_rd, wb_data and wb_src holding their previous values.
- **Writes to x0.** A request with rd==0 is still granted. It consumes the slot and advances the pointer, but produces wb_we=0.
- **No backpressure.** The register-file port is never stalled, so the arbiter accepts exactly one request whenever any req_valid is high.
- **Same-rd requests.** Several requesters targeting the same rd in one cycle are serialized by arbitration order. Program ordering between sources is the hazard unit's responsibility, not this block's.
- **Request stability.** A requester must hold req_valid, req_rd and req_data stable until granted. The arbiter does not check this.

## Timing
- Request granted in cycle N → wb_* valid in cycle N+1 → register file updated at the end of cycle N+1 → visible to register-file reads from cycle N+2.
- Throughput is 1 write per cycle.
- Worst-case wait for a continuously asserted request is NREQ-1 cycles.
- Reset asserted mid-cycle:
  - outputs clear asynchronously;
  - a grant issued in that cycle is lost;
  - the requester sees ready drop and keeps its request pending.
- Reset deasserted: the first grant can occur in the first full cycle after deassertion.

## Configuration
- **Macro `RF_WB_BYPASS_EN`, defined.** The rs1/rs2/fwd* ports exist.
  - fwdK_hit = wb_we & (rsK==wb_rd) & (rsK!=0), purely combinational.
  - fwdK_data = wb_data when hit, else 0.
  - This closes the cycle-N+1 window in which the register file still returns the stale value.
- **Macro undefined.** Those ports are absent and no compare logic is built. The hazard unit must stall decode one cycle after any writeback to a source register.

## Test plan
1. Reset mid-stream: all valid, reset pulsed in cycle 2 → req_ready=0 and wb_we=0 during reset; first grant after release goes to requester 0.
2. Single requester: req_valid=3'b010, rd=5, data=0xDEAD_BEEF → ready=3'b010 in cycle N; wb_we=1, wb_rd=5, wb_data=0xDEAD_BEEF, wb_src=1 in N+1; wb_we=0 in N+2.
3. Contention: all three valid continuously from reset → grants 0,1,2,0,1,2 in consecutive cycles; no requester waits more than 2 cycles.
4. Pointer hold and wrap: grant requester 2, then 3 idle cycles, then req_valid=3'b011 → requester 0 granted first, then requester 1.
5. x0 write: requester 0, rd=0, data=0x1234 → ready asserted; wb_we stays 0; next grant goes to requester 1.
6. Bypass (with RF_WB_BYPASS_EN): wb_we=1, wb_rd=7, wb_data=0x55; rs1=7, rs2=0 → fwd1_hit=1, fwd1_data=0x55, fwd2_hit=0. Same stimulus with wb_rd=0 → no hit.
